// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_pkg                                                     |
// | Description : Shared constants for the data-memory responder: MMIO        |
// |               register addresses, STATUS field positions, the RX-empty     |
// |               marker and a helper that assembles the STATUS word.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dmem_pkg;

    // Memory-mapped register word addresses
    localparam logic [31:0] ADDR_TX_DATA = 32'h0000_1000;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_1001;
    localparam logic [31:0] ADDR_RX_PEEK = 32'h0000_1002;
    localparam logic [31:0] ADDR_RX_POP  = 32'h0000_1003;

    // STATUS word bit positions
    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_RX_EMPTY   = 1;
    localparam int STAT_TX_OVF     = 2;
    localparam int STAT_RX_OVF     = 3;
    localparam int STAT_TX_CNT_LSB = 4;
    localparam int STAT_RX_CNT_LSB = 8;

    // RX_PEEK value returned when nothing is queued
    localparam logic [31:0] RX_EMPTY_MARK = 32'hFFFF_FFFF;

    // Count fields are only four bits wide; deeper FIFOs are truncated.
    function automatic logic [3:0] cnt4(input int unsigned c);
        return c[3:0];
    endfunction

    function automatic logic [31:0] pack_status(
        input logic       tx_full,
        input logic       rx_empty,
        input logic       tx_ovf,
        input logic       rx_ovf,
        input logic [3:0] tx_cnt,
        input logic [3:0] rx_cnt
    );
        logic [31:0] s;
        s                         = '0;
        s[STAT_TX_FULL]           = tx_full;
        s[STAT_RX_EMPTY]          = rx_empty;
        s[STAT_TX_OVF]            = tx_ovf;
        s[STAT_RX_OVF]            = rx_ovf;
        s[STAT_TX_CNT_LSB +: 4]   = tx_cnt;
        s[STAT_RX_CNT_LSB +: 4]   = rx_cnt;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : byte_fifo                                                    |
// | Description : Synchronous 8-bit FIFO with first-word fall-through head.   |
// |               A push while full is accepted only when a pop happens at    |
// |               the same edge; a pop while empty is ignored.                |
// | Ports       : clk, rst        - clock, synchronous active-high reset      |
// |               push_i, wdata_i - push request and byte                     |
// |               pop_i           - pop request                               |
// |               rdata_o         - head byte (valid when !empty_o)           |
// |               full_o, empty_o, count_o - occupancy                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          w_push_acc;
    logic          w_pop_acc;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign w_pop_acc  = pop_i && !empty_o;
    // A full FIFO still takes a byte when the head leaves at the same edge.
    assign w_push_acc = push_i && (!full_o || w_pop_acc);

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push_acc, w_pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Processor data-memory responder. RAM words at 0..RAM_WORDS-1 |
// |               with one-cycle registered read-before-write data; optional  |
// |               byte TX/RX FIFOs mapped at 0x1000..0x1003.                   |
// | Build macro : DMEM_RESPONDER_MMIO_EN - compiles in the FIFOs and MMIO      |
// |               registers; without it the block is RAM only.                 |
// | Ports       : clock, reset       - clock, synchronous active-high reset   |
// |               address_dmem, data, wren - processor access (word address)  |
// |               q_dmem             - registered read data                   |
// |               tx_data/valid/ready - TX byte stream out                    |
// |               rx_data/valid/ready - RX byte stream in                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [31:0]       q_dmem_q;
    logic [31:0]       w_rdata;
    logic              w_hit_mmio;
    logic              w_hit_ram;
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_ram_idx = address_dmem[RAM_AW-1:0];
    // MMIO decode takes precedence should RAM_WORDS ever overlap it.
    assign w_hit_ram = (address_dmem < 32'(RAM_WORDS)) && !w_hit_mmio;

    // RAM writes ignore reset: contents survive it and a coincident store lands.
    always_ff @(posedge clock) begin
        if (wren && w_hit_ram) begin
            ram_q[w_ram_idx] <= data;
        end
    end

`ifdef DMEM_RESPONDER_MMIO_EN
    logic             w_tx_wr;
    logic             w_tx_pop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [7:0]       w_tx_head;
    logic [CNT_W-1:0] w_tx_count;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [7:0]       w_rx_head;
    logic [CNT_W-1:0] w_rx_count;
    logic             w_stat_wr;
    logic             tx_ovf_q;
    logic             tx_ovf_d;
    logic             rx_ovf_q;
    logic             rx_ovf_d;
    logic [31:0]      w_status;

    assign w_hit_mmio = (address_dmem >= ADDR_TX_DATA) && (address_dmem <= ADDR_RX_POP);

    // MMIO stores are masked during reset.
    assign w_tx_wr   = wren && !reset && (address_dmem == ADDR_TX_DATA);
    assign w_stat_wr = wren && !reset && (address_dmem == ADDR_STATUS);
    assign w_rx_pop  = wren && !reset && (address_dmem == ADDR_RX_POP);
    assign w_tx_pop  = !w_tx_empty && tx_ready;
    // RX never uses the pop-while-full bypass: rx_ready alone gates a push.
    assign w_rx_push = rx_valid && !w_rx_full;

    byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (w_tx_wr),
        .wdata_i (data[7:0]),
        .pop_i   (w_tx_pop),
        .rdata_o (w_tx_head),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty),
        .count_o (w_tx_count)
    );

    byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (w_rx_push),
        .wdata_i (rx_data),
        .pop_i   (w_rx_pop),
        .rdata_o (w_rx_head),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty),
        .count_o (w_rx_count)
    );

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (w_tx_wr && w_tx_full && !w_tx_pop) begin
            tx_ovf_d = 1'b1;
        end else if (w_stat_wr) begin
            tx_ovf_d = 1'b0;
        end
        if (rx_valid && w_rx_full) begin
            rx_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    assign w_status = pack_status(w_tx_full, w_rx_empty, tx_ovf_q, rx_ovf_q,
                                  cnt4(32'(w_tx_count)), cnt4(32'(w_rx_count)));

    // Reads sample pre-edge state and have no side effects.
    always_comb begin
        w_rdata = '0;
        if (w_hit_ram) begin
            w_rdata = ram_q[w_ram_idx];
        end else if (address_dmem == ADDR_STATUS) begin
            w_rdata = w_status;
        end else if (address_dmem == ADDR_RX_PEEK) begin
            w_rdata = w_rx_empty ? RX_EMPTY_MARK : {24'b0, w_rx_head};
        end
    end

    assign tx_data  = w_tx_head;
    assign tx_valid = !w_tx_empty;
    assign rx_ready = !w_rx_full;
`else
    logic w_unused_inputs;

    assign w_hit_mmio      = 1'b0;
    assign w_unused_inputs = ^{tx_ready, rx_valid, rx_data};

    always_comb begin
        w_rdata = '0;
        if (w_hit_ram) begin
            w_rdata = ram_q[w_ram_idx];
        end
    end

    assign tx_data  = 8'h00;
    assign tx_valid = 1'b0;
    assign rx_ready = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem_q <= '0;
        end else begin
            q_dmem_q <= w_rdata;
        end
    end

    assign q_dmem = q_dmem_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                            |
// | Description : Self-checking bench for dmem_responder: queue-based model,   |
// |               directed scenarios with literal expectations, then random    |
// |               traffic. Follows DMEM_RESPONDER_MMIO_EN like the design.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int RAM_WORDS = 4096;
    localparam int DEPTH     = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .RAM_WORDS    (RAM_WORDS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ram_m [int];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    bit          tx_ovf_m  = 1'b0;
    bit          rx_ovf_m  = 1'b0;
    bit          model_ok  = 1'b0;
    logic [31:0] exp_q     = '0;
    bit          exp_known = 1'b0;

    always @(posedge clock) begin : p_model
        logic [31:0] a;
        bit          tx_pop;
        bit          tx_push;
        bit          tx_room;
        bit          rx_pop;
        bit          rx_room;
        a         = address_dmem;
        exp_known = 1'b1;
        exp_q     = '0;
        tx_pop    = 1'b0;
        tx_push   = 1'b0;
        tx_room   = 1'b0;
        rx_pop    = 1'b0;
        rx_room   = 1'b0;
        if (reset) begin
            exp_q = '0;
        end else if (a < 32'(RAM_WORDS)) begin
            if (ram_m.exists(int'(a))) exp_q = ram_m[int'(a)];
            else exp_known = 1'b0;
        end
`ifdef DMEM_RESPONDER_MMIO_EN
        else if (a == 32'h1001) begin
            exp_q = {20'b0, 4'(rxq.size()), 4'(txq.size()), rx_ovf_m, tx_ovf_m,
                     (rxq.size() == 0), (txq.size() == DEPTH)};
        end else if (a == 32'h1002) begin
            exp_q = (rxq.size() == 0) ? 32'hFFFF_FFFF : {24'b0, rxq[0]};
        end
`endif
        if (wren && (a < 32'(RAM_WORDS))) ram_m[int'(a)] = data;
        if (reset) begin
            txq.delete();
            rxq.delete();
            tx_ovf_m = 1'b0;
            rx_ovf_m = 1'b0;
            model_ok = 1'b1;
        end
`ifdef DMEM_RESPONDER_MMIO_EN
        else begin
            tx_pop  = (txq.size() > 0) && tx_ready;
            tx_push = wren && (a == 32'h1000);
            tx_room = (txq.size() < DEPTH) || tx_pop;
            rx_pop  = wren && (a == 32'h1003) && (rxq.size() > 0);
            rx_room = rxq.size() < DEPTH;
            if (tx_pop) void'(txq.pop_front());
            if (tx_push) begin
                if (tx_room) txq.push_back(data[7:0]);
                else tx_ovf_m = 1'b1;
            end
            if (wren && (a == 32'h1001)) tx_ovf_m = 1'b0;
            if (rx_pop) void'(rxq.pop_front());
            if (rx_valid) begin
                if (rx_room) rxq.push_back(rx_data);
                else rx_ovf_m = 1'b1;
            end
        end
`endif
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge clock) begin
        if (model_ok) begin
            if (exp_known) check("q_dmem", q_dmem, exp_q);
`ifdef DMEM_RESPONDER_MMIO_EN
            check("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
            if (txq.size() > 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
            check("rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
`else
            check("tx_valid tied", 32'(tx_valid), 32'd0);
            check("tx_data tied", 32'(tx_data), 32'd0);
            check("rx_ready tied", 32'(rx_ready), 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
        address_dmem = a;
        wren         = w;
        data         = d;
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        int          sel;
        int          mode;
        logic [31:0] a;
        logic [7:0]  e41 [8];

        reset = 1'b1; wren = 1'b0; address_dmem = '0; data = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        step(32'h0, 1'b0, 32'h0);
        step(32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        check("reset q_dmem", q_dmem, 32'h0);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
`ifdef DMEM_RESPONDER_MMIO_EN
        check("reset rx_ready", 32'(rx_ready), 32'd1);
`else
        check("reset rx_ready", 32'(rx_ready), 32'd0);
`endif

        // RAM read-before-write and one-cycle latency
        step(32'd5, 1'b1, 32'h1234_5678);
        step(32'd5, 1'b1, 32'hDEAD_BEEF);
        check("ram old word", q_dmem, 32'h1234_5678);
        step(32'd5, 1'b0, 32'h0);
        check("ram new word", q_dmem, 32'hDEAD_BEEF);

        // RAM store coincident with reset still lands
        reset = 1'b1;
        step(32'd6, 1'b1, 32'hCAFE_F00D);
        reset = 1'b0;
        step(32'd6, 1'b0, 32'h0);
        check("ram write in reset", q_dmem, 32'hCAFE_F00D);

`ifdef DMEM_RESPONDER_MMIO_EN
        // RX peek / pop
        rx_valid = 1'b1; rx_data = 8'hA5;
        step(32'h2000, 1'b0, 32'h0);
        rx_data = 8'h3C;
        step(32'h2000, 1'b0, 32'h0);
        rx_valid = 1'b0;
        step(32'h1002, 1'b0, 32'h0);
        check("rx peek A5", q_dmem, 32'h0000_00A5);
        step(32'h1003, 1'b1, 32'h0);
        step(32'h1002, 1'b0, 32'h0);
        check("rx peek 3C", q_dmem, 32'h0000_003C);
        step(32'h1003, 1'b1, 32'h0);
        step(32'h1002, 1'b0, 32'h0);
        check("rx peek empty", q_dmem, 32'hFFFF_FFFF);
        step(32'h1001, 1'b0, 32'h0);
        check("status rx empty", q_dmem, 32'h0000_0002);

        // TX overflow, then ordered drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) step(32'h1000, 1'b1, 32'(i));
        step(32'h1001, 1'b0, 32'h0);
        check("status tx full ovf", q_dmem, 32'h0000_0087);
        tx_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 20 && tx_valid; n++) begin
            check("tx order", 32'(tx_data), 32'(k + 1));
            k++;
            step(32'h2000, 1'b0, 32'h0);
        end
        check("tx drained count", 32'(k), 32'd8);
        step(32'h1001, 1'b1, 32'h0);
        step(32'h1001, 1'b0, 32'h0);
        check("status ovf cleared", q_dmem, 32'h0000_0002);

        // Push into a full TX FIFO at the same edge as a pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(32'h1000, 1'b1, 32'h11 + 32'(i));
        tx_ready = 1'b1;
        step(32'h1000, 1'b1, 32'h99);
        tx_ready = 1'b0;
        step(32'h1001, 1'b0, 32'h0);
        check("status full no ovf", q_dmem, 32'h0000_0083);
        for (int i = 0; i < 8; i++) e41[i] = (i < 7) ? (8'h12 + 8'(i)) : 8'h99;
        tx_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 20 && tx_valid; n++) begin
            if (k < 8) check("tx bypass order", 32'(tx_data), 32'(e41[k]));
            k++;
            step(32'h2000, 1'b0, 32'h0);
        end
        check("tx bypass count", 32'(k), 32'd8);

        // Reset mid-stream, with a TX store coincident with reset
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(32'h1000, 1'b1, 32'h40 + 32'(i));
        reset = 1'b1;
        step(32'h1000, 1'b1, 32'h77);
        reset = 1'b0;
        check("reset tx_valid mid", 32'(tx_valid), 32'd0);
        check("reset rx_ready mid", 32'(rx_ready), 32'd1);
        step(32'h1001, 1'b0, 32'h0);
        check("status after reset", q_dmem, 32'h0000_0002);
        step(32'd5, 1'b0, 32'h0);
        check("ram kept over reset", q_dmem, 32'hDEAD_BEEF);
`else
        // RAM-only build: MMIO window is unmapped
        step(32'h1000, 1'b1, 32'h55);
        check("no tx_valid", 32'(tx_valid), 32'd0);
        step(32'h1001, 1'b0, 32'h0);
        check("status unmapped", q_dmem, 32'h0);
        step(32'h1002, 1'b0, 32'h0);
        check("peek unmapped", q_dmem, 32'h0);
        check("rx_ready zero", 32'(rx_ready), 32'd0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            mode     = (n / 300) % 3;
            reset    = ($urandom_range(0, 149) == 0);
            tx_ready = (mode == 0) ? ($urandom_range(0, 7) == 0) :
                       (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            sel      = $urandom_range(0, 9);
            if (sel < 4) begin
                a = 32'($urandom_range(0, 15));
            end else if (sel == 4) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h0000_1004;
                    1:       a = 32'hFFFF_FFFF;
                    default: a = 32'h0001_1000;
                endcase
            end else begin
                a = 32'h1000 + 32'($urandom_range(0, 3));
            end
            step(a, 1'($urandom_range(0, 1)), $urandom);
        end
        reset = 1'b0; rx_valid = 1'b0;
        step(32'h2000, 1'b0, 32'h0);
        step(32'h2000, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
